twiddle_factor_fetch: RTL
=========================

// Module: twiddle_factor_fetch
// PURPOSE
//  Downstream of twiddle_pointers: converts per-stage twiddle pointers into signed Q8 twiddle factors
//  (256 = 1.0) for the butterfly array, one {real,imag} pair per stage per cycle.
//  Holds a runtime-loadable table of W_N^k, k = 0..N/2-1, and supports IFFT via conjugation.
//  Registered lookup with a 2-entry skid buffer so a stalled butterfly array back-pressures the pointer stage.
// PARAMETERS
//  N                8                          FFT size; power of two, >= 4
//  NUM_STAGES       $clog2(N)                  stages; one pointer/factor per stage
//  NUM_BUTTERFLIES  N/2                        table depth; pointer width = $clog2(NUM_BUTTERFLIES)
//  TW_WIDTH         16                         signed width of twiddle real/imag
// PORTS
//  clk               in   1                                    clock, rising edge
//  reset             in   1                                    asynchronous, active-high
//  enable            in   1                                    pointer vector valid this cycle
//  in_ready          out  1                                    block accepts pointer vector
//  twiddle_pointers  in   [NUM_STAGES][$clog2(NUM_BUTTERFLIES)]  table index per stage
//  inverse           in   1                                    1 = output conj(W) (IFFT)
//  tw_wr_en          in   1                                    table write strobe
//  tw_wr_addr        in   $clog2(NUM_BUTTERFLIES)              table write index
//  tw_wr_real        in   TW_WIDTH                             write data, real
//  tw_wr_imag        in   TW_WIDTH                             write data, imag
//  out_valid         out  1                                    factor vector valid
//  out_ready         in   1                                    consumer accepts factor vector
//  twiddle_real      out  [NUM_STAGES][TW_WIDTH]               factor real per stage
//  twiddle_imag      out  [NUM_STAGES][TW_WIDTH]               factor imag per stage
// BEHAVIOUR
//  - Reset (async): table entries all 0; out_valid=0, skid empty, twiddle_real/imag all 0, in_ready=1.
//  - Accept: enable && in_ready. Transfer out: out_valid && out_ready.
//  - Latency 1: vector accepted at edge t appears on outputs after t with out_valid=1 (output reg empty
//    or draining). Full throughput 1 vector/cycle while out_ready=1.
//  - Skid: accept while output reg full and not draining -> result stored in skid reg. in_ready = !skid_full
//    (registered). On drain, skid moves to output reg same edge; order strictly preserved.
//  - enable while in_ready=0: ignored, no data captured; upstream must hold.
//  - Outputs hold stable while out_valid && !out_ready.
//  - Lookup: real = table[ptr].real; imag = inverse ? -table[ptr].imag : table[ptr].imag.
//    inverse sampled at accept time, per vector. Negation saturates: -(-2^(TW_WIDTH-1)) -> 2^(TW_WIDTH-1)-1.
//  - Write: tw_wr_en updates table at edge. Same-cycle write and accept of same addr: lookup uses OLD value.
//    Writes allowed anytime; already-registered outputs/skid unaffected.
//  - Pointer >= NUM_BUTTERFLIES impossible by width; no range check.
//  - Reset mid-stream: outputs and skid cleared immediately, in-flight vectors dropped, table cleared.
// TESTING
//  1. Load table {256,0},{181,-181},{0,-256},{-181,-181}; pointers {0,1,2} enable 1 cycle ->
//     next cycle out_valid=1, real {256,181,0}, imag {0,-181,-256}.
//  2. Same table, inverse=1, pointers {3,2,1} -> real {-181,0,181}, imag {181,256,181}.
//  3. out_ready=0, 3 back-to-back enables -> first in output, second in skid, in_ready=0 for third
//     (not captured); out_ready=1 -> vectors 1,2 delivered in order, in_ready returns to 1.
//  4. Write addr1={100,-50} in same cycle as accept of ptr 1 -> output {181,-181}; next accept -> {100,-50}.
//  5. Entry {0,-32768}, inverse=1 -> imag 32767 (saturated).
//  6. Assert reset with out_valid=1 and skid full -> out_valid=0, outputs 0, in_ready=1 without clock edge.

Source files
------------

// File: rtl/twiddle_factor_fetch_if.sv
// twiddle_factor_fetch_if
//   Bundles the pointer-in / factor-out handshake and the table write port of
//   twiddle_factor_fetch.
//   master: pointer producer, table loader and factor consumer (drives enable,
//           pointers, inverse, table writes and out_ready).
//   slave : the fetch block (drives in_ready, out_valid and the factors).
interface twiddle_factor_fetch_if #(
   parameter int unsigned N        = 8,
   parameter int unsigned TW_WIDTH = 16
);
   localparam int unsigned NUM_STAGES      = $clog2(N);
   localparam int unsigned NUM_BUTTERFLIES = N / 2;
   localparam int unsigned PTR_WIDTH       = $clog2(NUM_BUTTERFLIES);

   logic                                  enable;
   logic                                  in_ready;
   logic [NUM_STAGES-1:0][PTR_WIDTH-1:0]  twiddle_pointers;
   logic                                  inverse;
   logic                                  tw_wr_en;
   logic [PTR_WIDTH-1:0]                  tw_wr_addr;
   logic [TW_WIDTH-1:0]                   tw_wr_real;
   logic [TW_WIDTH-1:0]                   tw_wr_imag;
   logic                                  out_valid;
   logic                                  out_ready;
   logic [NUM_STAGES-1:0][TW_WIDTH-1:0]   twiddle_real;
   logic [NUM_STAGES-1:0][TW_WIDTH-1:0]   twiddle_imag;

   modport master (
      output enable, twiddle_pointers, inverse, tw_wr_en, tw_wr_addr, tw_wr_real,
             tw_wr_imag, out_ready,
      input  in_ready, out_valid, twiddle_real, twiddle_imag
   );

   modport slave (
      input  enable, twiddle_pointers, inverse, tw_wr_en, tw_wr_addr, tw_wr_real,
             tw_wr_imag, out_ready,
      output in_ready, out_valid, twiddle_real, twiddle_imag
   );
endinterface

// File: rtl/twiddle_factor_fetch.sv
// twiddle_factor_fetch
//   Converts per-stage twiddle pointers into signed Q8 twiddle factors
//   (256 = 1.0), one {real, imag} pair per stage per accepted vector. Holds a
//   runtime-loadable table of W_N^k (k = 0..N/2-1); inverse selects conj(W)
//   with saturating negation. Registered lookup (latency 1) backed by a skid
//   register so a stalled consumer back-pressures the pointer stage.
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears table, output and skid
//   bus   : twiddle_factor_fetch_if.slave (pointer handshake, table write
//           port, factor handshake)
module twiddle_factor_fetch #(
   parameter int unsigned N               = 8,
   parameter int unsigned NUM_STAGES      = $clog2(N),
   parameter int unsigned NUM_BUTTERFLIES = N / 2,
   parameter int unsigned TW_WIDTH        = 16
) (
   input logic                   clk,
   input logic                   reset,
   twiddle_factor_fetch_if.slave bus
);
   localparam int unsigned PTR_WIDTH = $clog2(NUM_BUTTERFLIES);
   localparam logic [TW_WIDTH-1:0] TW_MIN = {1'b1, {(TW_WIDTH-1){1'b0}}};
   localparam logic [TW_WIDTH-1:0] TW_MAX = {1'b0, {(TW_WIDTH-1){1'b1}}};

   typedef logic [NUM_STAGES-1:0][TW_WIDTH-1:0] vec_t;

   // Occupancy: StOut = output register holds a vector, StFull = skid too.
   typedef enum logic [1:0] {StEmpty, StOut, StFull} state_e;

   state_e state_q, state_d;

   logic [TW_WIDTH-1:0] tbl_real_q [NUM_BUTTERFLIES];
   logic [TW_WIDTH-1:0] tbl_imag_q [NUM_BUTTERFLIES];

   vec_t lk_real, lk_imag;
   vec_t out_real_q, out_imag_q;
   vec_t skid_real_q, skid_imag_q;

   logic accept;
   logic load_out;
   logic load_from_skid;
   logic load_skid;

   assign bus.in_ready     = (state_q != StFull);
   assign bus.out_valid    = (state_q != StEmpty);
   assign bus.twiddle_real = out_real_q;
   assign bus.twiddle_imag = out_imag_q;
   assign accept           = bus.enable && bus.in_ready;

   // Reads the pre-write table, so a same-cycle write to the same entry is not seen.
   always_comb begin
      lk_real = '0;
      lk_imag = '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
         lk_real[s] = tbl_real_q[bus.twiddle_pointers[s]];
         if (!bus.inverse) begin
            lk_imag[s] = tbl_imag_q[bus.twiddle_pointers[s]];
         end else if (tbl_imag_q[bus.twiddle_pointers[s]] == TW_MIN) begin
            lk_imag[s] = TW_MAX;
         end else begin
            lk_imag[s] = -tbl_imag_q[bus.twiddle_pointers[s]];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      load_out       = 1'b0;
      load_from_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d  = StOut;
               load_out = 1'b1;
            end
         end
         StOut: begin
            if (bus.out_ready) begin
               if (accept) begin
                  load_out = 1'b1;
               end else begin
                  state_d = StEmpty;
               end
            end else if (accept) begin
               state_d   = StFull;
               load_skid = 1'b1;
            end
         end
         StFull: begin
            // in_ready is low here, so nothing new can arrive while draining.
            if (bus.out_ready) begin
               state_d        = StOut;
               load_from_skid = 1'b1;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_real_q  <= '0;
         out_imag_q  <= '0;
         skid_real_q <= '0;
         skid_imag_q <= '0;
      end else begin
         if (load_out) begin
            out_real_q <= lk_real;
            out_imag_q <= lk_imag;
         end else if (load_from_skid) begin
            out_real_q <= skid_real_q;
            out_imag_q <= skid_imag_q;
         end
         if (load_skid) begin
            skid_real_q <= lk_real;
            skid_imag_q <= lk_imag;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_BUTTERFLIES; k++) begin
            tbl_real_q[k] <= '0;
            tbl_imag_q[k] <= '0;
         end
      end else if (bus.tw_wr_en) begin
         tbl_real_q[bus.tw_wr_addr] <= bus.tw_wr_real;
         tbl_imag_q[bus.tw_wr_addr] <= bus.tw_wr_imag;
      end
   end
endmodule
